rr_req_client: RTL

// - Requester-side agent for one port of the 4-way round-robin fixed-time arbiter.
// - Queues burst jobs and drives one req line, and holds req until every beat of the burst has been granted.
// - Counts granted beats and flags starvation; instantiated once per arbiter port (req[i]/gnt[i]).

---
 rtl/rr_arb_pkg.sv | 17 +
 rtl/rr_job_fifo.sv | 58 +++++
 rtl/rr_req_client.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter and its per-port requester clients.
package rr_arb_pkg;

    localparam int NUM_PORTS = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } rr_state_e;

    // One-hot grant vectors as driven on the arbiter's gnt bus.
    localparam logic [NUM_PORTS-1:0] GNT_P0 = 4'b0001;
    localparam logic [NUM_PORTS-1:0] GNT_P1 = 4'b0010;
    localparam logic [NUM_PORTS-1:0] GNT_P2 = 4'b0100;
    localparam logic [NUM_PORTS-1:0] GNT_P3 = 4'b1000;

endpackage

// File: rtl/rr_job_fifo.sv
// Synchronous job FIFO; pointers carry an extra wrap bit so full/empty come straight from the flops.
module rr_job_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rr_req_client.sv
// Requester agent for one arbiter port: queues burst jobs, holds req for every beat, flags starvation.
module rr_req_client
    import rr_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4,
    parameter int TMO_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    output logic             req,
    input  logic             gnt,
    output logic             beat_fire,
    output logic             beat_last,
    output logic             busy,
    output logic             starve,
    input  logic             starve_clr,
    output rr_state_e        state_dbg
);

    localparam logic [TMO_W-1:0] TIMEOUT = '1;

    rr_state_e        state_q, state_d;
    logic [LEN_W:0]   beats_left_q, beats_left_d;
    logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             starve_q, starve_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LEN_W-1:0] head_len;
    logic [LEN_W:0]   head_beats;
    logic             active;
    logic             last_beat;

    // Handshake: a job transfers on a rising clk edge where job_valid && job_ready are both high.
    assign job_ready = !fifo_full;
    assign fifo_push = job_valid && job_ready;
    assign head_beats = {1'b0, head_len} + (LEN_W+1)'(1);

    rr_job_fifo #(
        .DEPTH (DEPTH),
        .W     (LEN_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (job_len),
        .pop   (fifo_pop),
        .dout  (head_len),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        active       = (state_q == ACTIVE);
        last_beat    = (beats_left_q == (LEN_W+1)'(1));
        beat_fire    = active && gnt && (beats_left_q != '0);
        beat_last    = beat_fire && last_beat;
        // A queued job is loaded on the last beat, so req only falls when nothing follows.
        req          = active && !(beat_last && fifo_empty);
        busy         = active || !fifo_empty;
        starve       = starve_q;
        state_dbg    = state_q;

        fifo_pop     = 1'b0;
        state_d      = state_q;
        beats_left_d = beats_left_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    state_d      = ACTIVE;
                    beats_left_d = head_beats;
                end
            end
            ACTIVE: begin
                if (beat_fire) begin
                    if (last_beat) begin
                        if (!fifo_empty) begin
                            fifo_pop     = 1'b1;
                            beats_left_d = head_beats;
                        end else begin
                            state_d      = IDLE;
                            beats_left_d = '0;
                        end
                    end else begin
                        beats_left_d = beats_left_q - (LEN_W+1)'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        wait_cnt_d = wait_cnt_q;
        if (!active || gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != TIMEOUT) begin
            wait_cnt_d = wait_cnt_q + TMO_W'(1);
        end

        starve_d = starve_q;
        if (starve_clr) begin
            starve_d = 1'b0;
        end
        if (wait_cnt_d == TIMEOUT) begin
            starve_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            wait_cnt_q   <= '0;
            starve_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_q     <= starve_d;
        end
    end

endmodule
